// File: rtl/swl_dmaburst.sv
// swl_dmaburst: multi-word Unibus DMA sequencer in front of the swlight ARM register port.
// ARM loads the start address, word count and direction, then starts the block. The sequencer
// takes the swlight DMA lock, runs one single-word swlight DMA per word and releases the lock.
// Data moves through a local FIFO, so ARM streams words instead of polling for each one.
//
// Ports
//   CLOCK, RESET_N      system clock, asynchronous active-low reset
//   armwrite            ARM register write strobe
//   armwaddr/armwdata   ARM write register select / write data
//   armraddr/armrdata   ARM read register select / read data (combinational)
//   sl_write            one-cycle write strobe into the swlight ARM port
//   sl_waddr/sl_wdata   swlight write register select / data
//   sl_raddr/sl_rdata   swlight read register select / data (sampled in the same cycle)
module swl_dmaburst #(
   parameter int unsigned DEPTHL2 = 4,
   parameter logic [31:0] LOCKKEY = 32'h42555253
) (
   input  logic        CLOCK,
   input  logic        RESET_N,
   input  logic        armwrite,
   input  logic [2:0]  armraddr,
   input  logic [2:0]  armwaddr,
   input  logic [31:0] armwdata,
   output logic [31:0] armrdata,
   output logic        sl_write,
   output logic [2:0]  sl_waddr,
   output logic [31:0] sl_wdata,
   output logic [2:0]  sl_raddr,
   input  logic [31:0] sl_rdata
);

   localparam int unsigned Depth = 1 << DEPTHL2;
   localparam logic [31:0] IdWord = 32'h44422001;

   typedef enum logic [3:0] {
      StIdle, StLock, StLchk, StXfer, StGo, StPoll, StRdat, StNext, StUnlk, StDone
   } state_t;

   state_t               r_state, w_state_d;
   logic [15:0]          r_fifo [Depth];
   logic [DEPTHL2-1:0]   r_wptr, r_rptr;
   logic [DEPTHL2:0]     r_level;
   logic                 r_abort, r_fail, r_ovf, r_dir;
   logic [15:0]          r_count;
   logic [17:0]          r_addr;

   logic                 w_idle, w_empty, w_full;
   logic [15:0]          w_head;
   logic [4:0]           w_level5;
   logic                 w_start, w_abort_req, w_addr_wr;
   logic                 w_arm_push, w_arm_pop;
   logic                 w_int_push, w_int_pop, w_next, w_set_fail;
   logic                 w_push, w_pop_ok, w_push_ok, w_drop;
   logic [15:0]          w_push_data;
   logic                 w_unused_bits;

   assign w_unused_bits = ^{armwdata[29:28], armwdata[26:18]};

   assign w_idle   = (r_state == StIdle);
   assign w_empty  = (r_level == '0);
   assign w_full   = (r_level == (DEPTHL2 + 1)'(Depth));
   assign w_head   = r_fifo[r_rptr];
   assign w_level5 = 5'(r_level);

   assign w_start     = armwrite && (armwaddr == 3'd1) && armwdata[31] && w_idle;
   assign w_abort_req = armwrite && (armwaddr == 3'd1) && armwdata[30] && !w_idle;
   assign w_addr_wr   = armwrite && (armwaddr == 3'd2) && w_idle;
   assign w_arm_push  = armwrite && (armwaddr == 3'd3);
   assign w_arm_pop   = armwrite && (armwaddr == 3'd4);

   // One FIFO write port: a DATI word from swlight wins over an ARM push in the same cycle,
   // and the losing ARM word is reported as an overflow. Simultaneous pops collapse to one.
   assign w_push      = w_int_push || w_arm_push;
   assign w_push_data = w_int_push ? sl_rdata[15:0] : armwdata[15:0];
   assign w_pop_ok    = (w_int_pop || w_arm_pop) && !w_empty;
   // A pop in the same cycle frees the slot, so full+push+pop accepts the push.
   assign w_push_ok   = w_push && (!w_full || w_pop_ok);
   assign w_drop      = (w_push && !w_push_ok) || (w_int_push && w_arm_push);

   // Sequencer next state and swlight port drive.
   always_comb begin
      w_state_d  = r_state;
      sl_write   = 1'b0;
      sl_waddr   = 3'd0;
      sl_wdata   = 32'd0;
      sl_raddr   = 3'd0;
      w_int_push = 1'b0;
      w_int_pop  = 1'b0;
      w_next     = 1'b0;
      w_set_fail = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_start && (armwdata[15:0] != 16'd0)) w_state_d = StLock;
         end
         StLock: begin
            sl_write  = 1'b1;
            sl_waddr  = 3'd5;
            sl_wdata  = LOCKKEY;
            w_state_d = StLchk;
         end
         StLchk: begin
            sl_raddr = 3'd5;
            // Once granted, an abort is handled in XFER so the lock is released.
            if (sl_rdata == LOCKKEY) w_state_d = StXfer;
            else if (r_abort)        w_state_d = StDone;
            else                     w_state_d = StLock;
         end
         StXfer: begin
            if (r_abort) begin
               w_state_d = StUnlk;
            end else if (r_dir) begin
               if (!w_empty) begin
                  sl_write  = 1'b1;
                  sl_waddr  = 3'd4;
                  sl_wdata  = {16'd0, w_head};
                  w_int_pop = 1'b1;
                  w_state_d = StGo;
               end
            end else if (!w_full) begin
               w_state_d = StGo;
            end
         end
         StGo: begin
            sl_write  = 1'b1;
            sl_waddr  = 3'd3;
            sl_wdata  = {2'b00, 1'b1, 1'b0, (r_dir ? 2'b10 : 2'b00), 8'd0, r_addr};
            w_state_d = StPoll;
         end
         StPoll: begin
            sl_raddr = 3'd3;
            if (sl_rdata[31:29] == 3'd0) begin
               if (sl_rdata[28]) begin
                  w_set_fail = 1'b1;
                  w_state_d  = StUnlk;
               end else begin
                  w_state_d  = r_dir ? StNext : StRdat;
               end
            end
         end
         StRdat: begin
            sl_raddr   = 3'd4;
            w_int_push = 1'b1;
            w_state_d  = StNext;
         end
         StNext: begin
            w_next    = 1'b1;
            w_state_d = (r_count == 16'd1) ? StUnlk : StXfer;
         end
         StUnlk: begin
            sl_write  = 1'b1;
            sl_waddr  = 3'd5;
            sl_wdata  = LOCKKEY;
            w_state_d = StDone;
         end
         StDone: begin
            w_state_d = StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_abort <= 1'b0;
         r_fail  <= 1'b0;
         r_ovf   <= 1'b0;
         r_dir   <= 1'b0;
         r_count <= 16'd0;
         r_addr  <= 18'd0;
      end else begin
         if (w_start) begin
            r_dir   <= armwdata[27];
            r_count <= armwdata[15:0];
            r_fail  <= 1'b0;
            r_ovf   <= 1'b0;
            r_abort <= 1'b0;
         end
         if (w_abort_req)         r_abort <= 1'b1;
         if (r_state == StDone)   r_abort <= 1'b0;
         if (w_addr_wr)           r_addr  <= armwdata[17:0];
         if (w_next) begin
            r_addr  <= r_addr + 18'd2;
            r_count <= r_count - 16'd1;
         end
         if (w_set_fail)          r_fail  <= 1'b1;
         if (w_drop)              r_ovf   <= 1'b1;
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + 1'b1;
         if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage needs no reset: the level counter guards every read.
   always_ff @(posedge CLOCK) begin
      if (w_push_ok) r_fifo[r_wptr] <= w_push_data;
   end

   always_comb begin
      armrdata = 32'd0;
      case (armraddr)
         3'd0: armrdata = IdWord;
         3'd1: armrdata = {!w_idle, r_abort, r_fail, r_ovf, r_dir, 1'b0, w_level5, 5'd0, r_count};
         3'd2: armrdata = {14'd0, r_addr};
         3'd3: armrdata = w_empty ? 32'd0 : {16'd0, w_head};
         default: armrdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_swl_dmaburst.sv
// Bench for swl_dmaburst: a small swlight stub (lock register, bus-cycle status, DATI data)
// plus a scoreboard of expected swlight writes checked as the DUT issues them.
module tb_swl_dmaburst;

   localparam logic [31:0] KEY = 32'h42555253;

   typedef struct {
      logic [2:0]  a;
      logic [31:0] d;
   } wr_t;

   logic        CLOCK = 1'b0;
   logic        RESET_N;
   logic        armwrite;
   logic [2:0]  armraddr, armwaddr;
   logic [31:0] armwdata, armrdata;
   logic        sl_write;
   logic [2:0]  sl_waddr, sl_raddr;
   logic [31:0] sl_wdata, sl_rdata;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_retry  = 0;
   logic        retry_ok;
   wr_t         exp_q[$];
   logic [15:0] fifo_q[$];

   // Stub state and configuration.
   logic [31:0] st_lock;
   int          st_hold, st_bsy, st_go_n;
   logic        cfg_take;
   int          cfg_fail_at;
   logic [31:0] cfg_dati [8];

   swl_dmaburst dut (
      .CLOCK    (CLOCK),
      .RESET_N  (RESET_N),
      .armwrite (armwrite),
      .armraddr (armraddr),
      .armwaddr (armwaddr),
      .armwdata (armwdata),
      .armrdata (armrdata),
      .sl_write (sl_write),
      .sl_waddr (sl_waddr),
      .sl_wdata (sl_wdata),
      .sl_raddr (sl_raddr),
      .sl_rdata (sl_rdata)
   );

   always #5 CLOCK = ~CLOCK;

   always @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         st_lock <= 32'd0;
         st_hold <= 0;
         st_bsy  <= 0;
         st_go_n <= 0;
      end else begin
         if (cfg_take) begin
            st_lock <= 32'd1;
            st_hold <= 10;
         end else if (st_hold != 0) begin
            st_hold <= st_hold - 1;
            if (st_hold == 1) st_lock <= 32'd0;
         end
         if (sl_write && sl_waddr == 3'd5 && sl_wdata == KEY) begin
            if (st_lock == 32'd0)    st_lock <= KEY;
            else if (st_lock == KEY) st_lock <= 32'd0;
         end
         if (sl_write && sl_waddr == 3'd3 && sl_wdata[29]) begin
            st_bsy  <= 3;
            st_go_n <= st_go_n + 1;
         end else if (st_bsy != 0) begin
            st_bsy <= st_bsy - 1;
         end
      end
   end

   always_comb begin
      sl_rdata = 32'd0;
      case (sl_raddr)
         3'd3: sl_rdata = (st_bsy != 0) ? 32'h2000_0000 : {3'b000, (st_go_n == cfg_fail_at), 28'd0};
         3'd4: sl_rdata = cfg_dati[st_go_n[2:0] - 3'd1];
         3'd5: sl_rdata = st_lock;
         default: sl_rdata = 32'd0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] go(input logic [17:0] a, input logic d);
      return 32'h2000_0000 | (d ? 32'h0800_0000 : 32'h0) | {14'd0, a};
   endfunction

   task automatic ex(input logic [2:0] a, input logic [31:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic sb_check();
      wr_t e;
      if (retry_ok && sl_waddr == 3'd5 && sl_wdata == KEY && st_lock != 32'd0 && st_lock != KEY)
         n_retry++;
      else if (exp_q.size() == 0)
         chk("sl_unexpected_write", 32'(exp_q.size()), 32'd1);
      else begin
         e = exp_q.pop_front();
         chk("sl_waddr", {29'd0, sl_waddr}, {29'd0, e.a});
         chk("sl_wdata", sl_wdata, e.d);
      end
   endtask

   task automatic arm_wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge CLOCK);
      armwaddr = a;
      armwdata = d;
      armwrite = 1'b1;
      @(negedge CLOCK);
      armwrite = 1'b0;
   endtask

   task automatic arm_rd(input logic [2:0] a, output logic [31:0] d);
      armraddr = a;
      #1;
      d = armrdata;
   endtask

   task automatic do_reset();
      @(negedge CLOCK);
      RESET_N     = 1'b0;
      armwrite    = 1'b0;
      cfg_take    = 1'b0;
      cfg_fail_at = 99;
      retry_ok    = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge CLOCK);
      RESET_N = 1'b1;
   endtask

   task automatic wait_done(input string tag);
      logic [31:0] v;
      v = 32'hFFFF_FFFF;
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLOCK);
         arm_rd(3'd1, v);
         if (!v[31] && exp_q.size() == 0) break;
      end
      chk({tag, "_busy"}, {31'd0, v[31]}, 32'd0);
      chk({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [31:0] v;
      RESET_N  = 1'b1;
      armwrite = 1'b0;
      armraddr = 3'd0;
      armwaddr = 3'd0;
      armwdata = 32'd0;
      cfg_take = 1'b0;
      cfg_fail_at = 99;
      retry_ok = 1'b0;
      for (int i = 0; i < 8; i++) cfg_dati[i] = 32'd0;
      fork
         forever begin
            @(negedge CLOCK);
            if (sl_write === 1'b1) sb_check();
         end
      join_none

      // Reset state.
      #2 RESET_N = 1'b0;
      #3;
      chk("rst_ctl", {28'd0, sl_write, sl_waddr}, 32'd0);
      chk("rst_raddr", {29'd0, sl_raddr}, 32'd0);
      chk("rst_wdata", sl_wdata, 32'd0);
      arm_rd(3'd0, v); chk("id", v, 32'h44422001);
      arm_rd(3'd1, v); chk("rst_reg1", v, 32'd0);
      arm_rd(3'd2, v); chk("rst_reg2", v, 32'd0);
      arm_rd(3'd3, v); chk("rst_reg3", v, 32'd0);
      @(negedge CLOCK);
      RESET_N = 1'b1;

      // Reset while a bus cycle is being polled.
      arm_wr(3'd3, 32'h1111);
      arm_wr(3'd3, 32'h2222);
      arm_wr(3'd2, 32'h100);
      ex(3'd5, KEY); ex(3'd4, 32'h1111); ex(3'd3, go(18'h100, 1'b1));
      arm_wr(3'd1, 32'h8800_0001);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge CLOCK);
      @(negedge CLOCK);
      chk("poll_raddr", {29'd0, sl_raddr}, 32'd3);
      RESET_N = 1'b0;
      #1;
      chk("midrst_ctl", {28'd0, sl_write, sl_waddr}, 32'd0);
      chk("midrst_raddr", {29'd0, sl_raddr}, 32'd0);
      chk("midrst_wdata", sl_wdata, 32'd0);
      arm_rd(3'd1, v); chk("midrst_reg1", v, 32'd0);
      arm_rd(3'd3, v); chk("midrst_reg3", v, 32'd0);

      // DATO 3 words.
      do_reset();
      for (int i = 1; i <= 3; i++) arm_wr(3'd3, 32'(i));
      arm_wr(3'd2, 32'o001000);
      ex(3'd5, KEY);
      for (int i = 0; i < 3; i++) begin
         ex(3'd4, 32'(i + 1));
         ex(3'd3, go(18'o001000 + 18'(2 * i), 1'b1));
      end
      ex(3'd5, KEY);
      arm_wr(3'd1, 32'h8800_0003);
      wait_done("dato");
      arm_rd(3'd1, v); chk("dato_reg1", v, 32'h0800_0000);
      arm_rd(3'd2, v); chk("dato_addr", v, 32'o001006);
      chk("dato_unlocked", st_lock, 32'd0);

      // DATI 2 words; only the low 16 bits of the bus data land in the FIFO.
      do_reset();
      cfg_dati[0] = 32'o123456;
      cfg_dati[1] = 32'o654321;
      fifo_q.push_back(16'o123456);
      fifo_q.push_back(16'(32'o654321));
      arm_wr(3'd2, 32'o002000);
      ex(3'd5, KEY); ex(3'd3, go(18'o002000, 1'b0)); ex(3'd3, go(18'o002002, 1'b0)); ex(3'd5, KEY);
      arm_wr(3'd1, 32'h8000_0002);
      wait_done("dati");
      arm_rd(3'd1, v); chk("dati_reg1", v, 32'h0040_0000);
      while (fifo_q.size() != 0) begin
         arm_rd(3'd3, v);
         chk("dati_head", v, {16'd0, fifo_q.pop_front()});
         arm_wr(3'd4, 32'd0);
      end
      arm_rd(3'd3, v); chk("dati_empty", v, 32'd0);
      arm_wr(3'd4, 32'd0);
      arm_rd(3'd1, v); chk("pop_empty_level", {27'd0, v[25:21]}, 32'd0);

      // Lock held by another owner for 10 cycles.
      do_reset();
      arm_wr(3'd3, 32'h0AAA);
      arm_wr(3'd2, 32'h10);
      @(negedge CLOCK); cfg_take = 1'b1;
      @(negedge CLOCK); cfg_take = 1'b0;
      retry_ok = 1'b1;
      n_retry  = 0;
      ex(3'd5, KEY); ex(3'd4, 32'h0AAA); ex(3'd3, go(18'h10, 1'b1)); ex(3'd5, KEY);
      arm_wr(3'd1, 32'h8800_0001);
      wait_done("lock");
      retry_ok = 1'b0;
      chk("lock_retries", (n_retry >= 2) ? 32'd1 : 32'd0, 32'd1);
      chk("lock_released", st_lock, 32'd0);

      // Failure on word 2 of 4.
      do_reset();
      for (int i = 1; i <= 4; i++) arm_wr(3'd3, 32'(16 * i + i));
      arm_wr(3'd2, 32'o004000);
      cfg_fail_at = 2;
      ex(3'd5, KEY);
      ex(3'd4, 32'h11); ex(3'd3, go(18'o004000, 1'b1));
      ex(3'd4, 32'h22); ex(3'd3, go(18'o004002, 1'b1));
      ex(3'd5, KEY);
      arm_wr(3'd1, 32'h8800_0004);
      wait_done("fail");
      arm_rd(3'd1, v); chk("fail_reg1", v, 32'h2840_0003);
      arm_rd(3'd2, v); chk("fail_addr", v, 32'o004002);
      chk("fail_unlocked", st_lock, 32'd0);

      // Zero count: no swlight traffic, never busy.
      do_reset();
      arm_wr(3'd1, 32'h8800_0000);
      repeat (10) @(negedge CLOCK);
      arm_rd(3'd1, v); chk("zero_reg1", v, 32'h0800_0000);

      // 17 pushes: the last one is dropped.
      for (int i = 0; i < 17; i++) arm_wr(3'd3, 32'h100 + 32'(i));
      arm_rd(3'd1, v); chk("ovf_reg1", v, 32'h1A00_0000);
      arm_rd(3'd3, v); chk("ovf_head", v, 32'h100);

      // Address wrap at the top of the 18-bit space.
      do_reset();
      arm_wr(3'd3, 32'hBEEF);
      arm_wr(3'd3, 32'hCAFE);
      arm_wr(3'd2, 32'o777776);
      ex(3'd5, KEY);
      ex(3'd4, 32'hBEEF); ex(3'd3, go(18'o777776, 1'b1));
      ex(3'd4, 32'hCAFE); ex(3'd3, go(18'd0, 1'b1));
      ex(3'd5, KEY);
      arm_wr(3'd1, 32'h8800_0002);
      wait_done("wrap");
      arm_rd(3'd2, v); chk("wrap_addr", v, 32'd2);

      // Abort while DATI is stalled on a full FIFO.
      do_reset();
      for (int i = 0; i < 16; i++) arm_wr(3'd3, 32'(i));
      ex(3'd5, KEY); ex(3'd5, KEY);
      arm_wr(3'd1, 32'h8000_0003);
      repeat (6) @(negedge CLOCK);
      arm_rd(3'd1, v); chk("stall_busy", {31'd0, v[31]}, 32'd1);
      arm_wr(3'd1, 32'h4000_0000);
      wait_done("abort");
      arm_rd(3'd1, v); chk("abort_reg1", v, 32'h0200_0003);
      chk("abort_unlocked", st_lock, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
